// File: rtl/anode_scan_driver.sv
// anode_scan_driver
// Multiplexed seven-segment scan engine. Walks through NUM_DIGITS digit slots
// of PRESCALE cycles each. Every slot starts with a blanking interval for
// anti-ghosting, followed by an on phase that is PWM-gated by a brightness
// value. Mask and brightness are captured once per slot. All port outputs
// come straight from flops, and those flops are loaded from the next-state
// values so that the pins line up with the internal slot counter.
module anode_scan_driver #(
    parameter  int NUM_DIGITS   = 4,
    parameter  int PRESCALE     = 100000,
    parameter  int BLANK_CYCLES = 1000,
    parameter  int DUTY_BITS    = 4,
    localparam int SEL_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [NUM_DIGITS-1:0] digit_Mask,
    input  logic [DUTY_BITS-1:0]  brightness,
    output logic [NUM_DIGITS-1:0] anode_Out,
    output logic [SEL_W-1:0]      digit_Sel,
    output logic                  scan_Tick,
    output logic                  frame_Start
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [SEL_W-1:0] DIGIT_LAST = SEL_W'(NUM_DIGITS - 1);

    // run_q remembers that the previous cycle was a scanning cycle, so that
    // the first enabled cycle can be forced to slot 0 of digit 0.
    logic                  run_q,    run_d;
    logic [CNT_W-1:0]      slot_q,   slot_d;
    logic [SEL_W-1:0]      digit_q,  digit_d;
    logic [DUTY_BITS-1:0]  pwm_q,    pwm_d;
    logic [NUM_DIGITS-1:0] mask_q,   mask_d;
    logic [DUTY_BITS-1:0]  bright_q, bright_d;
    logic [NUM_DIGITS-1:0] anode_q,  anode_d;
    logic                  tick_q,   tick_d;
    logic                  frame_q,  frame_d;

    // Next-state computation for the counters, the per-slot samples and the
    // output values that belong to the next cycle.
    always_comb begin
        run_d    = enable;
        slot_d   = '0;
        digit_d  = '0;
        pwm_d    = '0;
        mask_d   = mask_q;
        bright_d = bright_q;
        anode_d  = '1;
        tick_d   = 1'b0;
        frame_d  = 1'b0;
        if (enable) begin
            if (!run_q) begin
                slot_d  = '0;
                digit_d = '0;
            end else if (slot_q == SLOT_LAST) begin
                slot_d  = '0;
                digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;
            end else begin
                slot_d  = slot_q + 1'b1;
                digit_d = digit_q;
            end
            if (slot_d == '0) begin
                mask_d   = digit_Mask;
                bright_d = brightness;
            end
            tick_d  = (slot_d == '0);
            frame_d = (slot_d == '0) && (digit_d == '0);
            if (int'(slot_d) > BLANK_CYCLES) begin
                pwm_d = pwm_q + 1'b1;
            end
            if ((int'(slot_d) >= BLANK_CYCLES) && (pwm_d <= bright_d)) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if ((digit_d == SEL_W'(i)) && mask_d[i]) begin
                        anode_d[i] = 1'b0;
                    end
                end
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_q    <= 1'b0;
            slot_q   <= '0;
            digit_q  <= '0;
            pwm_q    <= '0;
            mask_q   <= '0;
            bright_q <= '0;
            anode_q  <= '1;
            tick_q   <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            run_q    <= run_d;
            slot_q   <= slot_d;
            digit_q  <= digit_d;
            pwm_q    <= pwm_d;
            mask_q   <= mask_d;
            bright_q <= bright_d;
            anode_q  <= anode_d;
            tick_q   <= tick_d;
            frame_q  <= frame_d;
        end
    end

    assign anode_Out   = anode_q;
    assign digit_Sel   = digit_q;
    assign scan_Tick   = tick_q;
    assign frame_Start = frame_q;

endmodule

// File: tb/tb_anode_scan_driver.sv
// tb_anode_scan_driver
// Drives two scan engines (4 digits / 32-cycle slots / 4 blank cycles, and
// 2 digits / 8-cycle slots / no blanking) from shared inputs and compares
// every cycle against an arithmetic model indexed by enabled-cycle count.
module tb_anode_scan_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] digit_mask;
    logic [1:0] brightness;

    logic [3:0] a1;
    logic [1:0] sel1;
    logic       tick1, frame1;
    logic [1:0] a2;
    logic [0:0] sel2;
    logic       tick2, frame2;

    int compared   = 0;
    int mismatched = 0;

    // Model state: n counts enabled cycles since scanning (re)started, -1 when idle.
    int         n = -1;
    logic [3:0] capMask1 = '0;
    logic [1:0] capBr1 = '0;
    logic [1:0] capMask2 = '0;
    logic [1:0] capBr2 = '0;

    anode_scan_driver #(
        .NUM_DIGITS(4), .PRESCALE(32), .BLANK_CYCLES(4), .DUTY_BITS(2)
    ) dut1 (
        .clk(clk), .reset(reset), .enable(enable),
        .digit_Mask(digit_mask), .brightness(brightness),
        .anode_Out(a1), .digit_Sel(sel1), .scan_Tick(tick1), .frame_Start(frame1)
    );

    anode_scan_driver #(
        .NUM_DIGITS(2), .PRESCALE(8), .BLANK_CYCLES(0), .DUTY_BITS(2)
    ) dut2 (
        .clk(clk), .reset(reset), .enable(enable),
        .digit_Mask(digit_mask[1:0]), .brightness(brightness),
        .anode_Out(a2), .digit_Sel(sel2), .scan_Tick(tick2), .frame_Start(frame2)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Expected anode word for enabled-cycle index cnt under the given geometry.
    function automatic logic [15:0] expAnode(int cnt, int p, int b, int db, int d,
                                             logic [15:0] m, int br);
        logic [15:0] r;
        int slot, dig, pwm;
        r = '1;
        if (cnt < 0) return r;
        slot = cnt % p;
        dig  = (cnt / p) % d;
        if (slot < b) return r;
        pwm = (slot - b) % (1 << db);
        if (m[dig] && (pwm <= br)) r[dig] = 1'b0;
        return r;
    endfunction

    task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic [15:0] e1, e2;
        e1 = expAnode(n, 32, 4, 2, 4, {12'h0, capMask1}, int'(capBr1));
        e2 = expAnode(n, 8, 0, 2, 2, {14'h0, capMask2}, int'(capBr2));
        checkVal("anode1", {12'h0, a1}, {12'h0, e1[3:0]});
        checkVal("sel1",   {14'h0, sel1}, (n < 0) ? 16'd0 : 16'((n / 32) % 4));
        checkVal("tick1",  {15'h0, tick1}, {15'h0, (n >= 0) && (n % 32 == 0)});
        checkVal("frame1", {15'h0, frame1}, {15'h0, (n >= 0) && (n % 128 == 0)});
        checkVal("anode2", {14'h0, a2}, {14'h0, e2[1:0]});
        checkVal("sel2",   {15'h0, sel2}, (n < 0) ? 16'd0 : 16'((n / 8) % 2));
        checkVal("tick2",  {15'h0, tick2}, {15'h0, (n >= 0) && (n % 8 == 0)});
        checkVal("frame2", {15'h0, frame2}, {15'h0, (n >= 0) && (n % 16 == 0)});
        checkVal("onehot1", {15'h0, ($countones(~a1) <= 1)}, 16'd1);
        checkVal("onehot2", {15'h0, ($countones(~a2) <= 1)}, 16'd1);
    endtask

    // One clock: the model consumes the inputs seen at the edge, then outputs are checked.
    task automatic applyStimulus();
        @(posedge clk);
        if (reset || !enable) n = -1;
        else n = n + 1;
        if (n >= 0 && n % 32 == 0) begin
            capMask1 = digit_mask;
            capBr1   = brightness;
        end
        if (n >= 0 && n % 8 == 0) begin
            capMask2 = digit_mask[1:0];
            capBr2   = brightness;
        end
        #1;
        checkOutput();
    endtask

    task automatic runCycles(input int k);
        for (int i = 0; i < k; i++) applyStimulus();
    endtask

    task automatic runUntilSlot(input int slot, input int dig);
        int guard;
        guard = 0;
        while (!(n >= 0 && n % 32 == slot && (n / 32) % 4 == dig) && guard < 1000) begin
            applyStimulus();
            guard++;
        end
        checkVal("align_timeout", {15'h0, guard >= 1000}, 16'd0);
    endtask

    // Counts cycles with any lit anode over one whole dut1 slot.
    task automatic countSlotLows(input string tag, input int exp);
        int lows;
        runUntilSlot(31, 3);
        lows = 0;
        for (int i = 0; i < 32; i++) begin
            applyStimulus();
            if (a1 != 4'hF) lows++;
        end
        checkVal(tag, 16'(lows), 16'(exp));
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b1;
        digit_mask = 4'hF;
        brightness = 2'd3;
        runCycles(3);

        $display("[TB] basic scan, full brightness");
        reset = 1'b0;
        runCycles(140);

        $display("[TB] brightness 0 and 1");
        brightness = 2'd0;
        countSlotLows("lows_b0", 7);
        runCycles(40);
        brightness = 2'd1;
        countSlotLows("lows_b1", 14);
        runCycles(40);

        $display("[TB] digit mask 0101, mid-slot change");
        brightness = 2'd3;
        digit_mask = 4'b0101;
        runCycles(140);
        runUntilSlot(10, 1);
        digit_mask = 4'b1111;
        runCycles(60);

        $display("[TB] enable drop at digit 2 slot cycle 10");
        runUntilSlot(10, 2);
        enable = 1'b0;
        runCycles(6);
        enable = 1'b1;
        runCycles(50);

        $display("[TB] reset mid-slot with enable high");
        runUntilSlot(17, 1);
        reset = 1'b1;
        runCycles(2);
        reset = 1'b0;
        runCycles(50);

        $display("[TB] randomized inputs");
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(15) == 0) digit_mask = 4'($urandom);
            if ($urandom_range(15) == 0) brightness = 2'($urandom);
            if ($urandom_range(63) == 0) enable = ~enable;
            else if (!enable && $urandom_range(3) == 0) enable = 1'b1;
            reset = ($urandom_range(127) == 0);
            applyStimulus();
        end
        reset = 1'b0;
        enable = 1'b1;
        runCycles(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/anode_scan_driver.md
Name: anode_scan_driver

Overview:
- Parametrised multiplexed-display scan engine that generates active-low anode enables for NUM_DIGITS seven-segment digits.
- Also outputs the current digit index, which drives the segment-data mux.
- Adds a per-digit refresh timer, an inter-digit blanking interval (anti-ghosting), per-digit enable masking and PWM brightness control.
- Sits between the clock-display datapath and the board anode pins; replaces the fixed 2-to-4 anode decode.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; legal range 2..16.
- PRESCALE, 100000, clock cycles per digit slot; must exceed BLANK_CYCLES by at least 2^DUTY_BITS.
- BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; 0 is legal.
- DUTY_BITS, 4, width of the brightness control.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  scan enable; low blanks the display and holds the counters at 0
- digit_Mask  input  NUM_DIGITS  bit i = 1 allows digit i to light
- brightness  input  DUTY_BITS  on-phase duty select
- anode_Out  output  NUM_DIGITS  active-low anode enables; 1 = off
- digit_Sel  output  max(1,$clog2(NUM_DIGITS))  index of the digit owning the current slot
- scan_Tick  output  1  one-cycle pulse on slot cycle 0
- frame_Start  output  1  one-cycle pulse on slot cycle 0 of digit 0

Behaviour:
- Single clock domain. Reset is synchronous and active-high, and dominates enable.
- Reset values: anode_Out all ones, digit_Sel 0, scan_Tick 0, frame_Start 0. Internal slot_cnt, pwm_cnt and digit index are all 0.
- Slot counter:
  - slot_cnt counts 0..PRESCALE-1 while enable=1, then wraps to 0.
  - On the wrap, digit index increments; NUM_DIGITS-1 wraps to 0.
  - Masked digits still consume their full slot, so refresh rate is independent of the mask.
- Slot cycle 0 is the cycle in which scan_Tick=1 and digit_Sel already shows the new index. All slot timing below counts from that cycle.
- First slot timing: on the first cycle after reset deasserts with enable=1, slot_cnt=0. In that cycle scan_Tick=1, frame_Start=1 and digit_Sel=0.
- Slot-start sampling: digit_Mask and brightness are sampled at slot cycle 0 and held for the rest of the slot. Mid-slot changes take effect at the next slot.
- Blank phase: slot cycles 0..BLANK_CYCLES-1 drive anode_Out to all ones.
- On phase: slot cycles BLANK_CYCLES..PRESCALE-1.
  - pwm_cnt (DUTY_BITS wide) is 0 at the first on-phase cycle and increments every cycle, wrapping.
  - Digit d is lit (anode_Out[d]=0) when d == digit index, sampled mask bit d = 1, and pwm_cnt <= sampled brightness.
  - At most one anode is low in any cycle.
  - brightness = all ones gives 100% of the on phase; brightness = 0 gives 1/2^DUTY_BITS.
- anode_Out is driven from a register (glitch-free pins). It is cycle-aligned with slot_cnt as defined above, so no additional latency is visible at the ports.
- enable low:
  - In the next cycle anode_Out goes to all ones and scan_Tick and frame_Start go to 0.
  - slot_cnt, pwm_cnt and digit index clear to 0 and hold.
- enable rise: the first cycle with enable=1 is slot cycle 0 of digit 0, with scan_Tick=1 and frame_Start=1.
- Reset mid-slot: outputs return to reset values in the next cycle. Scanning restarts from digit 0 after release.
- Simultaneous events: reset beats enable. Slot wrap and digit wrap happen in the same cycle, and frame_Start then coincides with scan_Tick.
- Frame period is NUM_DIGITS*PRESCALE cycles exactly.

Test Plan:
All scenarios use NUM_DIGITS=4, PRESCALE=32, BLANK_CYCLES=4, DUTY_BITS=2, unless stated otherwise.
- Reset and release, enable=1, mask=4'b1111, brightness=3:
  - scan_Tick on cycles 0, 32, 64, 96, 128 after release; frame_Start on cycles 0 and 128.
  - digit_Sel sequence 0,1,2,3,0.
  - anode_Out=4'b1111 for cycles 0-3, then 4'b1110 for cycles 4-31; digit 1 gets 4'b1101 for cycles 36-63.
- Brightness=0, mask=4'b1111:
  - In each slot the owning anode is low for exactly 7 of 28 on-phase cycles, at slot cycles 4, 8, ..., 28.
  - brightness=1 gives 14 cycles low.
- mask=4'b0101:
  - Digits 1 and 3 never go low; slot timing and digit_Sel are unchanged.
  - Changing the mask to 4'b1111 mid-slot of digit 1 leaves digit 1 dark until its next slot.
- enable dropped at slot cycle 10 of digit 2:
  - Next cycle anode_Out=4'b1111 and digit_Sel=0, held there.
  - On re-enable: scan_Tick=1, frame_Start=1 and digit_Sel=0 in the first enabled cycle.
- reset asserted together with enable=1 mid-slot: reset wins, all outputs take reset values, and the scan restarts at digit 0.
- Parameter sweep NUM_DIGITS=2, BLANK_CYCLES=0:
  - digit_Sel toggles 0,1; the owning anode is low from slot cycle 0.
  - A one-hot-zero check holds on anode_Out every cycle.
